// File: rtl/alu_pkg.sv
// Shared types for the ALU command path.
//   alu_op_e  : 3-bit ALU opcode. The issue unit passes it through and never
//               interprets it.
//   alu_cmd_t : one queued command {op, a, b} at the default ALU width.
package alu_pkg;

  localparam int ALU_N = 4;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    DEC = 3'd2,
    INC = 3'd3,
    NOT = 3'd4,
    AND = 3'd5,
    OR  = 3'd6,
    XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e          op;
    logic [ALU_N-1:0] a;
    logic [ALU_N-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Command and result handshake bundle for alu_issue_unit.
//   cmd_* : producer -> unit, valid/ready command channel
//   res_* : unit -> consumer, valid/ready result channel
// The slave modport is the unit side. The master modport is the
// producer/consumer side.
interface alu_issue_unit_if #(parameter int N = 4);
  import alu_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  alu_op_e       cmd_opcode;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;

  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_y;
  logic          res_overflow;
  alu_op_e       res_opcode;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_y, res_overflow, res_opcode
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_y, res_overflow, res_opcode
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// In-order command storage for alu_issue_unit.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of pointers and count
//   push/wdata : write request. It is ignored when full.
//   pop        : drop the head entry. It is ignored when empty.
//   rdata      : head entry. It is combinational from storage and only
//                meaningful when !empty.
//   count      : occupancy. It has one extra bit so that full (DEPTH) is
//                distinct from empty (0).
//   full/empty : occupancy flags
module alu_cmd_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Full blocks a push even when a pop happens on the same edge. This keeps
  // cmd_ready a pure function of occupancy.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset. The empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Command queue and result register around a combinational ALU.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous clear of the queue and the result register
//   bus (slave)  : cmd_* command handshake in, res_* result handshake out
//   alu_opcode/alu_a/alu_b : head command driven to the ALU. All are zero
//                  when the queue is empty.
//   alu_y/alu_overflow     : ALU response, captured on issue
//   count        : queue occupancy. The result register is not counted.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  alu_issue_unit_if.slave          bus,
  output logic [2:0]               alu_opcode,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  input  logic [N-1:0]             alu_y,
  input  logic                     alu_overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = 3 + 2*N;

  logic [CW-1:0] head;
  logic          q_full, q_empty;
  logic          issue;

  logic          res_valid_q;
  logic [N-1:0]  res_y_q;
  logic          res_ovf_q;
  alu_op_e       res_op_q;

  // Issue whenever a head exists and the result slot is free or being
  // drained this edge. A command pushed into an empty queue becomes the
  // head only after its push edge, so it issues one edge later.
  assign issue = !q_empty && (!res_valid_q || bus.res_ready);

  alu_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (bus.cmd_valid),
    .wdata ({bus.cmd_opcode, bus.cmd_a, bus.cmd_b}),
    .pop   (issue),
    .rdata (head),
    .count (count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.cmd_ready = !q_full;

  always_comb begin
    {alu_opcode, alu_a, alu_b} = q_empty ? '0 : head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_ovf_q   <= 1'b0;
      res_op_q    <= ADD;
    end else if (flush) begin
      res_valid_q <= 1'b0;
    end else if (issue) begin
      res_valid_q <= 1'b1;
      res_y_q     <= alu_y;
      res_ovf_q   <= alu_overflow;
      res_op_q    <= alu_op_e'(alu_opcode);
    end else if (res_valid_q && bus.res_ready) begin
      // Drain only. The data fields hold their last value.
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid    = res_valid_q;
  assign bus.res_y        = res_y_q;
  assign bus.res_overflow = res_ovf_q;
  assign bus.res_opcode   = res_op_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [2:0] alu_opcode;
  logic [N-1:0] alu_a, alu_b, alu_y;
  logic alu_overflow;
  logic [$clog2(DEPTH):0] count;

  alu_issue_unit_if #(.N(N)) bus ();

  alu_issue_unit #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_overflow (alu_overflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  // ALU behaviour: overflow is the carry out of add/inc and the borrow of
  // sub/dec. It is zero for the logic ops.
  function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {1'b0, a} - {1'b0, b};
      DEC:     return {1'b0, a} - 5'd1;
      INC:     return {1'b0, a} + 5'd1;
      NOT:     return {1'b0, ~a};
      AND:     return {1'b0, a & b};
      OR:      return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always_comb {alu_overflow, alu_y} = alu_fn(alu_opcode, alu_a, alu_b);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending commands plus one result slot.
  alu_cmd_t   mq[$];
  bit         m_rv;
  logic [3:0] m_y;
  bit         m_ovf;
  logic [2:0] m_op;

  task automatic model_reset();
    mq.delete();
    m_rv = 0; m_y = '0; m_ovf = 0; m_op = '0;
  endtask

  task automatic model_step(input bit v, input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b, input bit rr, input bit fl);
    alu_cmd_t h;
    bit iss, psh;
    if (fl) begin
      mq.delete();
      m_rv = 0;
    end else begin
      psh = v && (mq.size() < DEPTH);
      iss = (mq.size() > 0) && (!m_rv || rr);
      if (iss) begin
        h = mq.pop_front();
        {m_ovf, m_y} = alu_fn(h.op, h.a, h.b);
        m_op = h.op;
        m_rv = 1;
      end else if (m_rv && rr) begin
        m_rv = 0;
      end
      if (psh) begin
        h.op = alu_op_e'(op); h.a = a; h.b = b;
        mq.push_back(h);
      end
    end
  endtask

  task automatic check_outputs();
    logic [10:0] exp_head;
    exp_head = (mq.size() > 0) ? {mq[0].op, mq[0].a, mq[0].b} : 11'd0;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(mq.size() < DEPTH));
    chk("count", 32'(count), 32'(mq.size()));
    chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
    chk("res_y", 32'(bus.res_y), 32'(m_y));
    chk("res_ovf", 32'(bus.res_overflow), 32'(m_ovf));
    chk("res_op", 32'(bus.res_opcode), 32'(m_op));
    chk("alu_head", 32'({alu_opcode, alu_a, alu_b}), 32'(exp_head));
  endtask

  // One clock: drive after negedge, check settled outputs, advance the
  // model, then cross the rising edge and return at the next negedge.
  task automatic cyc(input bit v, input logic [2:0] op, input logic [3:0] a,
                     input logic [3:0] b, input bit rr, input bit fl);
    bus.cmd_valid  = v;
    bus.cmd_opcode = alu_op_e'(op);
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.res_ready  = rr;
    flush          = fl;
    #1;
    check_outputs();
    model_step(v, op, a, b, rr, fl);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = ADD; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.res_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;

    // ADD 9+8 -> y=1, ovf=1, one edge after accept
    cyc(1, ADD, 4'd9, 4'd8, 1, 0);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);
    chk("add_valid", 32'(bus.res_valid), 32'd1);
    chk("add_y", 32'(bus.res_y), 32'h1);
    chk("add_ovf", 32'(bus.res_overflow), 32'd1);
    chk("add_op", 32'(bus.res_opcode), 32'd0);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);

    // SUB 3-5 then XOR A^5 back to back
    cyc(1, SUB, 4'd3, 4'd5, 1, 0);
    cyc(1, XOR, 4'hA, 4'd5, 1, 0);
    chk("sub_y", 32'(bus.res_y), 32'hE);
    chk("sub_ovf", 32'(bus.res_overflow), 32'd1);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);
    chk("xor_y", 32'(bus.res_y), 32'hF);
    chk("xor_ovf", 32'(bus.res_overflow), 32'd0);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);

    // Back-pressure: stream INC 0..9 with the consumer stalled
    for (int i = 0; i < 10; i++) cyc(1, INC, 4'(i), 4'd0, 0, 0);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_ready", 32'(bus.cmd_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_y", 32'(bus.res_y), 32'(k + 1));
      cyc(0, INC, 4'd0, 4'd0, 1, 0);
      if (k == 0) chk("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
    end
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);

    // Flush with three queued and a result held
    for (int i = 0; i < 4; i++) cyc(1, OR, 4'(i), 4'd3, 0, 0);
    chk("fl_pre_count", 32'(count), 32'd3);
    chk("fl_pre_valid", 32'(bus.res_valid), 32'd1);
    cyc(1, ADD, 4'd7, 4'd7, 0, 1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(bus.res_valid), 32'd0);
    chk("fl_ready", 32'(bus.cmd_ready), 32'd1);
    cyc(1, ADD, 4'd1, 4'd1, 1, 0);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);
    chk("fl_add_y", 32'(bus.res_y), 32'h2);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);

    // Async reset between edges, mid-stream
    cyc(1, SUB, 4'd9, 4'd2, 0, 0);
    cyc(1, DEC, 4'd4, 4'd0, 0, 0);
    cyc(1, NOT, 4'd6, 4'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, AND, 4'hC, 4'hA, 1, 0);
    cyc(0, ADD, 4'd0, 4'd0, 1, 0);
    chk("rst_and_y", 32'(bus.res_y), 32'h8);
    chk("rst_and_op", 32'(bus.res_opcode), 32'(AND));

    // Randomized traffic with occasional flush and stalls
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, 3'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
